muldiv_iter: RTL and testbench

Iterative unsigned multiply/divide unit in the EX stage. Consumes the same operand pair as the ALU: rs1 data on data1_i, and the output of the ALUSrc 32-bit operand mux on data2_i. Computes one result bit per cycle, so a MUL/MULHU/DIVU/REMU needs WIDTH+1 cycles. The pipeline stalls on busy_o and captures data_o when done_o pulses.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 55 +++++
 rtl/muldiv_iter.sv | 167 ++++++++++++++++
 tb/tb_muldiv_iter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: op encodings, FSM state enum, default datapath width XLEN.
package muldiv_pkg;

    localparam int XLEN = 32;

    // Bit 1 of the op selects divide; bit 0 selects the "other half" of the result.
    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One shift-add multiply or restoring divide iteration (purely combinational).
// Latency: 0 cycles.
// Backpressure: none; the caller decides when to register the outputs.
// Ports:
//   is_div          : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi / lo         : current {hi, lo} product halves, or {R, Q} for divide
//   opnd            : multiplicand (multiply) or divisor (divide)
//   hi_nxt / lo_nxt : values after this iteration
import muldiv_pkg::*;

module muldiv_step #(
    parameter int WIDTH = XLEN
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shr;
    logic [WIDTH:0]   div_t;
    logic [WIDTH-1:0] div_shq;

    always_comb begin
        // Multiply: conditionally add the multiplicand into hi (keeping the
        // carry), then shift {carry, hi, lo} right by one.
        mul_sum = {1'b0, hi};
        if (lo[0]) begin
            mul_sum = {1'b0, hi} + {1'b0, opnd};
        end

        // Divide: shift {R, Q} left, then trial-subtract the divisor. R never
        // exceeds WIDTH bits (R < divisor, or R is a dividend prefix when the
        // divisor is zero), so only the shifted-in bit widens it.
        div_shr = {hi, lo[WIDTH-1]};
        div_shq = {lo[WIDTH-2:0], 1'b0};
        div_t   = div_shr - {1'b0, opnd};

        hi_nxt = mul_sum[WIDTH:1];
        lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
        if (is_div) begin
            if (!div_t[WIDTH]) begin
                hi_nxt = div_t[WIDTH-1:0];
                lo_nxt = {div_shq[WIDTH-1:1], 1'b1};
            end else begin
                hi_nxt = div_shr[WIDTH-1:0];
                lo_nxt = div_shq;
            end
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit, one result bit per cycle.
// Latency: done_o WIDTH+1 cycles after start_i (1 cycle for trivial zero cases
//   when MULDIV_FAST_ZERO_EN is defined); one op per WIDTH+1 cycles.
// Backpressure: busy_o stalls the pipeline; start_i is ignored while busy_o=1.
// Optional feature macro: MULDIV_FAST_ZERO_EN (zero-operand shortcut).
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   start_i, op_i     : request pulse and operation (sampled together)
//   data1_i, data2_i  : rs1 operand, operand-mux output
//   busy_o, done_o    : in-flight flag, one-cycle completion pulse
//   data_o            : result, held until the next completion
import muldiv_pkg::*;

module muldiv_iter #(
    parameter int WIDTH = XLEN
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state;
    state_e           state_nxt;
    logic [CNT_W-1:0] cnt;
    op_e              op_q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi_nxt;
    logic [WIDTH-1:0] lo_nxt;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             finish;
    logic             fast_hit;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div (op_q[1]),
        .hi     (hi),
        .lo     (lo),
        .opnd   (opnd),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // MUL and DIVU take the low/quotient half; MULHU and REMU the high/remainder half.
    always_comb begin
        result = lo_nxt;
        if (op_q == OP_MULHU || op_q == OP_REMU) begin
            result = hi_nxt;
        end
    end

`ifdef MULDIV_FAST_ZERO_EN
    logic [WIDTH-1:0] fast_res;

    // Cases whose answer is known without iterating; values match what the
    // full iteration would produce.
    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
        case (op_e'(op_i))
            OP_MUL, OP_MULHU: begin
                fast_hit = (data1_i == '0) || (data2_i == '0);
                fast_res = '0;
            end
            OP_DIVU: begin
                fast_hit = (data2_i == '0);
                fast_res = '1;
            end
            OP_REMU: begin
                fast_hit = (data2_i == '0);
                fast_res = data1_i;
            end
            default: begin
                fast_hit = 1'b0;
                fast_res = '0;
            end
        endcase
    end
`else
    assign fast_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    accept    = 1'b1;
                    state_nxt = fast_hit ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt == CNT_LAST) begin
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= '0;
            op_q   <= OP_MUL;
            hi     <= '0;
            lo     <= '0;
            opnd   <= '0;
            data_o <= '0;
        end else if (accept) begin
            cnt  <= '0;
            op_q <= op_e'(op_i);
            hi   <= '0;
            // Multiply iterates over the multiplier (data2) in lo; divide
            // shifts the dividend (data1) out of Q.
            if (op_i[1]) begin
                lo   <= data1_i;
                opnd <= data2_i;
            end else begin
                lo   <= data2_i;
                opnd <= data1_i;
            end
`ifdef MULDIV_FAST_ZERO_EN
            if (fast_hit) begin
                data_o <= fast_res;
            end
`endif
        end else if (state == S_RUN) begin
            cnt <= cnt + 1'b1;
            hi  <= hi_nxt;
            lo  <= lo_nxt;
            if (finish) begin
                data_o <= result;
            end
        end
    end

    assign busy_o = (state == S_RUN);
    assign done_o = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_iter.sv
module tb_muldiv_iter;

    localparam int W    = 32;
    localparam int NLAT = W + 1;
`ifdef MULDIV_FAST_ZERO_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = W + 1;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] dout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[14];

    muldiv_iter #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .op_i    (op),
        .data1_i (a),
        .data2_i (b),
        .busy_o  (busy),
        .done_o  (done),
        .data_o  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Drives a start pulse in the current cycle (cycle 0).
    task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
    endtask

    // Counts cycles until done_o, checks latency, busy cycles and result.
    // glitch_cyc > 0 drives an unrelated start pulse in that cycle.
    task automatic await_done(input string nm, input int exp_lat, input logic [W-1:0] exp_dat,
                              input int glitch_cyc);
        int cyc    = 0;
        int busy_n = 0;
        bit seen   = 1'b0;
        while (!seen && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else if (busy) busy_n++;
            if (cyc == glitch_cyc) begin
                start = 1'b1;
                op    = 2'b10;
                a     = 32'd100;
                b     = 32'd7;
            end else begin
                start = 1'b0;
            end
        end
        chk({nm, " latency"}, seen ? W'(cyc) : W'(0), W'(exp_lat));
        chk({nm, " busy cycles"}, W'(busy_n), W'(exp_lat - 1));
        chk({nm, " data"}, dout, exp_dat);
    endtask

    initial begin
        int done_n;

        vecs[0]  = '{"MUL 7x6",        2'b00, 32'd7,        32'd6,        32'h0000002A, NLAT};
        vecs[1]  = '{"MULHU ff*ff",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, NLAT};
        vecs[2]  = '{"MUL ff*ff",      2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, NLAT};
        vecs[3]  = '{"DIVU 100/7",     2'b10, 32'd100,      32'd7,        32'h0000000E, NLAT};
        vecs[4]  = '{"REMU 100/7",     2'b11, 32'd100,      32'd7,        32'h00000002, NLAT};
        vecs[5]  = '{"DIVU x/0",       2'b10, 32'h12345678, 32'd0,        32'hFFFFFFFF, ZLAT};
        vecs[6]  = '{"REMU x/0",       2'b11, 32'h12345678, 32'd0,        32'h12345678, ZLAT};
        vecs[7]  = '{"MUL 0x5",        2'b00, 32'd0,        32'd5,        32'h00000000, ZLAT};
        vecs[8]  = '{"MULHU 2^31x4",   2'b01, 32'h80000000, 32'd4,        32'h00000002, NLAT};
        vecs[9]  = '{"DIVU max/1",     2'b10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, NLAT};
        vecs[10] = '{"DIVU 5/9",       2'b10, 32'd5,        32'd9,        32'h00000000, NLAT};
        vecs[11] = '{"REMU 5/9",       2'b11, 32'd5,        32'd9,        32'h00000005, NLAT};
        vecs[12] = '{"MULHU x*16",     2'b01, 32'h12345678, 32'h10,       32'h00000001, NLAT};
        vecs[13] = '{"MUL x*16",       2'b00, 32'h12345678, 32'h10,       32'h23456780, NLAT};

        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", W'(busy), W'(0));
        chk("reset done", W'(done), W'(0));
        chk("reset data", dout, W'(0));
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            await_done(vecs[i].name, vecs[i].lat, vecs[i].exp, 0);
            @(negedge clk);
            chk({vecs[i].name, " done pulse width"}, W'(done), W'(0));
            chk({vecs[i].name, " data held"}, dout, vecs[i].exp);
        end

        // Start pulse in the middle of RUN must not disturb the operation.
        launch(2'b00, 32'd7, 32'd6);
        await_done("MUL 7x6 mid-run start", NLAT, 32'h0000002A, 10);

        // Back-to-back: new op accepted in the DONE cycle of the previous one.
        launch(2'b10, 32'd9, 32'd3);
        await_done("DIVU 9/3", NLAT, 32'h00000003, 0);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd3;
        b     = 32'd3;
        await_done("b2b MUL 3x3", NLAT, 32'h00000009, 0);

        // Reset ten cycles into an operation aborts it without a done pulse.
        launch(2'b00, 32'd7, 32'd6);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid-op reset busy", W'(busy), W'(0));
        chk("mid-op reset done", W'(done), W'(0));
        chk("mid-op reset data", dout, W'(0));
        @(negedge clk);
        rst    = 1'b0;
        done_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        chk("no done after abort", W'(done_n), W'(0));

        launch(2'b11, 32'd100, 32'd7);
        await_done("REMU after reset", NLAT, 32'h00000002, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
